err_compute: RTL

- Upstream stage of the PID error path.
- Sweeps 8 IR sensor channels through the shared A2D with a start/complete handshake.
- Forms a signed, position-weighted left/right difference, scales it and saturates it to 10 bits.
- Presents the result as err_sat with a one-cycle err_vld strobe, consumed directly by the P/I/D term stages.

---
 rtl/err_compute_if.sv | 23 ++
 rtl/err_compute.sv | 101 ++++++++++
 2 files changed

// File: rtl/err_compute_if.sv
// Handshake and result bundle between the IR sweep/error stage and its A2D and PID neighbours.
// The slave modport is the err_compute block; the master side drives go and the A2D return path.
interface err_compute_if;
    logic        go;
    logic        cnv_cmplt;
    logic [11:0] a2d_res;
    logic        strt_cnv;
    logic [2:0]  a2d_chnnl;
    logic        IR_en;
    logic        busy;
    logic [9:0]  err_sat;
    logic        err_vld;

    modport master (
        output go, cnv_cmplt, a2d_res,
        input  strt_cnv, a2d_chnnl, IR_en, busy, err_sat, err_vld
    );

    modport slave (
        input  go, cnv_cmplt, a2d_res,
        output strt_cnv, a2d_chnnl, IR_en, busy, err_sat, err_vld
    );
endinterface

// File: rtl/err_compute.sv
// Sweeps 8 IR channels through the A2D, accumulates a position-weighted left/right difference,
// then shifts and saturates it into a 10-bit signed error with a one-cycle valid strobe.
module err_compute #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned SHIFT      = 3
) (
    input logic          clk,
    input logic          rst_n,
    err_compute_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSettle, StStart, StWait, StDone} state_t;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);

    state_t             state;
    logic [7:0]         settle_cnt;
    logic signed [16:0] acc;

    logic [14:0]        prod;
    logic signed [16:0] term;
    logic signed [16:0] acc_upd;
    logic signed [16:0] shifted;
    logic [9:0]         sat;

    // Pair index ch[2:1] selects weight 1/2/4/8; even channels are left (subtract).
    assign prod    = {3'b000, bus.a2d_res} << bus.a2d_chnnl[2:1];
    assign term    = signed'({2'b00, prod});
    assign acc_upd = bus.a2d_chnnl[0] ? (acc + term) : (acc - term);
    assign shifted = acc >>> SHIFT;

    always_comb begin
        sat = shifted[9:0];
        if (shifted > 17'sd511) begin
            sat = 10'h1FF;
        end else if (shifted < -17'sd512) begin
            sat = 10'h200;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            settle_cnt    <= 8'd0;
            acc           <= 17'sd0;
            bus.strt_cnv  <= 1'b0;
            bus.a2d_chnnl <= 3'd0;
            bus.IR_en     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err_sat   <= 10'd0;
            bus.err_vld   <= 1'b0;
        end else begin
            bus.strt_cnv <= 1'b0;
            bus.err_vld  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.go) begin
                        state         <= StSettle;
                        acc           <= 17'sd0;
                        bus.a2d_chnnl <= 3'd0;
                        settle_cnt    <= 8'd0;
                        bus.IR_en     <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                StSettle: begin
                    if (settle_cnt == SettleLast) begin
                        state        <= StStart;
                        bus.strt_cnv <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                StStart: begin
                    state <= StWait;
                end
                StWait: begin
                    if (bus.cnv_cmplt) begin
                        acc <= acc_upd;
                        if (bus.a2d_chnnl == 3'd7) begin
                            state <= StDone;
                        end else begin
                            bus.a2d_chnnl <= bus.a2d_chnnl + 3'd1;
                            state         <= StStart;
                            bus.strt_cnv  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    bus.err_sat <= sat;
                    bus.err_vld <= 1'b1;
                    bus.IR_en   <= 1'b0;
                    bus.busy    <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
